spi_accel_responder: RTL and testbench

SPI responder that emulates the ADXL345-style accelerometer register interface seen by the signal path's SPI master (mode 3, active-low chip select, 8-bit command byte followed by data bytes). It serves sample data loaded from a parallel source and holds the configuration registers that the master writes. The block is the accelerometer-side end of the GSENSOR link: it drives the master under simulation and replays recorded or synthetic acceleration data on hardware via GPIO.

---
 rtl/spi_accel_responder.sv | 200 ++++++++++++++++++++
 tb/tb_spi_accel_responder.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_accel_responder.sv
// ADXL345-style SPI mode-3 responder: config registers plus a
// frame-coherent snapshot of the latest acceleration sample.
module spi_accel_responder #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] DEVID       = 8'hE5
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        spi_sclk,
    input  logic        spi_cs,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    input  logic [15:0] x_sample,
    input  logic [15:0] y_sample,
    input  logic [15:0] z_sample,
    input  logic        sample_valid,
    output logic        int1,
    output logic [7:0]  bw_rate,
    output logic [7:0]  power_ctl,
    output logic        frame_done
);

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    state_t state;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic sclk_prev;
    logic cs_prev;

    logic [2:0]  bitcnt;
    logic [6:0]  rx_shift;
    logic [7:0]  tx_shift;
    logic        rw;
    logic        mb;
    logic [5:0]  addr;
    logic [47:0] staging;
    logic [47:0] snapshot;
    logic        data_ready;
    logic        fresh;
    logic        read_sample;
    logic [7:0]  int_enable;
    logic [7:0]  data_format;
    logic [7:0]  rd_byte;

    logic sclk_s;
    logic cs_s;
    logic sclk_rise;
    logic sclk_fall;
    logic cs_rise;
    logic cs_fall;
    logic [7:0] rx_byte;
    logic is_sample;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign cs_rise   = cs_s & ~cs_prev;
    assign cs_fall   = ~cs_s & cs_prev;
    assign rx_byte   = {rx_shift, mosi_sync[SYNC_STAGES-1]};
    assign is_sample = (addr >= 6'h32) && (addr <= 6'h37);
    assign int1      = data_ready & int_enable[7];

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            sclk_sync <= '1;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_prev <= 1'b1;
            cs_prev   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sclk_prev <= sclk_s;
            cs_prev   <= cs_s;
        end
    end

    always_comb begin
        rd_byte = 8'h00;
        case (addr)
            6'h00:   rd_byte = DEVID;
            6'h2C:   rd_byte = bw_rate;
            6'h2D:   rd_byte = power_ctl;
            6'h2E:   rd_byte = int_enable;
            6'h30:   rd_byte = {data_ready, 7'b0};
            6'h31:   rd_byte = data_format;
            6'h32:   rd_byte = snapshot[7:0];
            6'h33:   rd_byte = snapshot[15:8];
            6'h34:   rd_byte = snapshot[23:16];
            6'h35:   rd_byte = snapshot[31:24];
            6'h36:   rd_byte = snapshot[39:32];
            6'h37:   rd_byte = snapshot[47:40];
            default: rd_byte = 8'h00;
        endcase
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            bitcnt      <= 3'd0;
            rx_shift    <= 7'd0;
            tx_shift    <= 8'd0;
            rw          <= 1'b0;
            mb          <= 1'b0;
            addr        <= 6'd0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            frame_done  <= 1'b0;
            data_ready  <= 1'b0;
            fresh       <= 1'b0;
            read_sample <= 1'b0;
            staging     <= 48'd0;
            snapshot    <= 48'd0;
            bw_rate     <= 8'h0A;
            power_ctl   <= 8'h00;
            int_enable  <= 8'h00;
            data_format <= 8'h00;
        end else begin
            frame_done <= 1'b0;
            if (sample_valid) begin
                staging    <= {z_sample, y_sample, x_sample};
                data_ready <= 1'b1;
                fresh      <= 1'b1;
            end
            if (cs_rise) begin
                state       <= IDLE;
                spi_miso    <= 1'b0;
                spi_miso_oe <= 1'b0;
                frame_done  <= 1'b1;
                // a sample that arrived mid-frame was not read, keep it flagged
                if (!sample_valid && read_sample && !fresh)
                    data_ready <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (cs_fall) begin
                            state       <= CMD;
                            bitcnt      <= 3'd0;
                            snapshot    <= staging;
                            read_sample <= 1'b0;
                            if (!sample_valid)
                                fresh <= 1'b0;
                        end
                    end
                    CMD: begin
                        if (sclk_rise) begin
                            rx_shift <= rx_byte[6:0];
                            bitcnt   <= bitcnt + 3'd1;
                            if (bitcnt == 3'd7) begin
                                rw    <= rx_byte[7];
                                mb    <= rx_byte[6];
                                addr  <= rx_byte[5:0];
                                state <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        if (sclk_fall) begin
                            if (bitcnt == 3'd0) begin
                                tx_shift    <= {rd_byte[6:0], 1'b0};
                                spi_miso    <= rw & rd_byte[7];
                                spi_miso_oe <= rw;
                                if (rw && is_sample)
                                    read_sample <= 1'b1;
                            end else begin
                                tx_shift <= {tx_shift[6:0], 1'b0};
                                spi_miso <= rw & tx_shift[7];
                            end
                        end
                        if (sclk_rise) begin
                            rx_shift <= rx_byte[6:0];
                            bitcnt   <= bitcnt + 3'd1;
                            if (bitcnt == 3'd7) begin
                                if (!rw) begin
                                    case (addr)
                                        6'h2C:   bw_rate     <= rx_byte;
                                        6'h2D:   power_ctl   <= rx_byte;
                                        6'h2E:   int_enable  <= rx_byte;
                                        6'h31:   data_format <= rx_byte;
                                        default: ;
                                    endcase
                                end
                                if (mb)
                                    addr <= addr + 6'd1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_accel_responder.sv
// Self-checking bench: SPI master driver plus a register-map model
// derived from the accelerometer register rules.
module tb_spi_accel_responder;

    localparam int HALF = 8;

    logic        sys_clk = 1'b0;
    logic        reset;
    logic        spi_sclk;
    logic        spi_cs;
    logic        spi_mosi;
    logic        spi_miso;
    logic        spi_miso_oe;
    logic [15:0] x_sample;
    logic [15:0] y_sample;
    logic [15:0] z_sample;
    logic        sample_valid;
    logic        int1;
    logic [7:0]  bw_rate;
    logic [7:0]  power_ctl;
    logic        frame_done;

    spi_accel_responder dut (
        .sys_clk      (sys_clk),
        .reset        (reset),
        .spi_sclk     (spi_sclk),
        .spi_cs       (spi_cs),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso),
        .spi_miso_oe  (spi_miso_oe),
        .x_sample     (x_sample),
        .y_sample     (y_sample),
        .z_sample     (z_sample),
        .sample_valid (sample_valid),
        .int1         (int1),
        .bw_rate      (bw_rate),
        .power_ctl    (power_ctl),
        .frame_done   (frame_done)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks;
    int n_fail;
    bit quiet;

    logic [7:0]  txb [16];
    logic [7:0]  rxb [16];
    logic [15:0] inj_x, inj_y, inj_z;

    logic [7:0] m_bw, m_pc, m_ie, m_df;
    logic       m_dr;
    logic       m_fresh;
    logic [7:0] m_stage [6];
    logic [7:0] m_snap [6];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    function automatic logic [7:0] sbyte(input logic [15:0] x, y, z,
                                         input int k);
        logic [47:0] w;
        w = {z, y, x};
        return w[8*k +: 8];
    endfunction

    function automatic logic [7:0] exp_rd(input logic [5:0] a);
        if (a == 6'h00) return 8'hE5;
        if (a == 6'h2C) return m_bw;
        if (a == 6'h2D) return m_pc;
        if (a == 6'h2E) return m_ie;
        if (a == 6'h30) return {m_dr, 7'b0};
        if (a == 6'h31) return m_df;
        if (a >= 6'h32 && a <= 6'h37) return m_snap[a - 6'h32];
        return 8'h00;
    endfunction

    task automatic model_reset();
        m_bw = 8'h0A; m_pc = 8'h00; m_ie = 8'h00; m_df = 8'h00;
        m_dr = 1'b0; m_fresh = 1'b0;
        for (int k = 0; k < 6; k++) begin
            m_stage[k] = 8'h00;
            m_snap[k]  = 8'h00;
        end
    endtask

    always @(negedge sys_clk) begin
        if (quiet) begin
            chk("bw_rate", bw_rate, m_bw);
            chk("power_ctl", power_ctl, m_pc);
            chk("int1", int1, m_dr & m_ie[7]);
            chk("miso_oe_idle", spi_miso_oe, 1'b0);
            chk("miso_idle", spi_miso, 1'b0);
            chk("frame_done_idle", frame_done, 1'b0);
        end
    end

    task automatic pulse_sample(input logic [15:0] x, y, z);
        x_sample = x; y_sample = y; z_sample = z;
        sample_valid = 1'b1;
        for (int k = 0; k < 6; k++) m_stage[k] = sbyte(x, y, z, k);
        m_dr = 1'b1;
        m_fresh = 1'b1;
        wait_cyc(1);
        sample_valid = 1'b0;
    endtask

    task automatic sample_idle(input logic [15:0] x, y, z);
        quiet = 1'b0;
        pulse_sample(x, y, z);
        wait_cyc(2);
        quiet = 1'b1;
    endtask

    task automatic model_frame(input int nbits);
        logic [5:0] a;
        logic rwm, mbm;
        bit rd_s;
        rd_s = 1'b0;
        if (nbits >= 8) begin
            rwm = txb[0][7];
            mbm = txb[0][6];
            a   = txb[0][5:0];
            for (int b = 1; 8*b < nbits; b++) begin
                if (rwm && a >= 6'h32 && a <= 6'h37) rd_s = 1'b1;
                if (nbits >= 8*(b+1)) begin
                    if (rwm) begin
                        chk("rd_byte", rxb[b], exp_rd(a));
                    end else begin
                        if (a == 6'h2C) m_bw = txb[b];
                        if (a == 6'h2D) m_pc = txb[b];
                        if (a == 6'h2E) m_ie = txb[b];
                        if (a == 6'h31) m_df = txb[b];
                    end
                    if (mbm) a = a + 6'd1;
                end
            end
        end
        if (rd_s && !m_fresh) m_dr = 1'b0;
    endtask

    task automatic run_frame(input int nbits, input int inj_at);
        int b, i, pulses;
        quiet = 1'b0;
        for (int k = 0; k < 16; k++) rxb[k] = 8'h00;
        for (int k = 0; k < 6; k++) m_snap[k] = m_stage[k];
        m_fresh = 1'b0;
        wait_cyc(1);
        spi_cs = 1'b0;
        wait_cyc(HALF);
        for (int k = 0; k < nbits; k++) begin
            b = k / 8;
            i = 7 - (k % 8);
            if (i == 7 && b == inj_at) pulse_sample(inj_x, inj_y, inj_z);
            spi_sclk = 1'b0;
            spi_mosi = txb[b][i];
            wait_cyc(HALF);
            rxb[b][i] = spi_miso;
            if (i == 0)
                chk("miso_oe_frame", spi_miso_oe, (b > 0) ? txb[0][7] : 1'b0);
            spi_sclk = 1'b1;
            wait_cyc(HALF);
        end
        spi_cs = 1'b1;
        model_frame(nbits);
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            wait_cyc(1);
            if (frame_done) begin
                pulses++;
                chk("int1_at_frame_done", int1, m_dr & m_ie[7]);
            end
        end
        chk("frame_done_pulses", pulses, 1);
        wait_cyc(2);
        quiet = 1'b1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_miso"}, spi_miso, 1'b0);
        chk({tag, "_miso_oe"}, spi_miso_oe, 1'b0);
        chk({tag, "_frame_done"}, frame_done, 1'b0);
        chk({tag, "_int1"}, int1, 1'b0);
        chk({tag, "_bw_rate"}, bw_rate, 8'h0A);
        chk({tag, "_power_ctl"}, power_ctl, 8'h00);
    endtask

    initial begin
        logic [15:0] ax, ay, az;
        int nb, nbits;
        logic [5:0] ra;
        n_checks = 0;
        n_fail = 0;
        quiet = 1'b0;
        reset = 1'b1;
        spi_sclk = 1'b1;
        spi_cs = 1'b1;
        spi_mosi = 1'b0;
        sample_valid = 1'b0;
        x_sample = '0; y_sample = '0; z_sample = '0;
        inj_x = '0; inj_y = '0; inj_z = '0;
        model_reset();
        wait_cyc(4);
        chk_reset_vals("por");
        reset = 1'b0;
        wait_cyc(4);
        quiet = 1'b1;

        txb[0] = 8'h2D; txb[1] = 8'h55;
        run_frame(16, -1);
        chk("pc_pre_reset", power_ctl, 8'h55);
        txb[0] = 8'h2E; txb[1] = 8'h80;
        run_frame(16, -1);
        sample_idle(16'h1111, 16'h2222, 16'h3333);
        chk("int1_pre_reset", int1, 1'b1);

        quiet = 1'b0;
        spi_cs = 1'b0;
        wait_cyc(HALF);
        for (int k = 0; k < 3; k++) begin
            spi_sclk = 1'b0; spi_mosi = 1'b1;
            wait_cyc(HALF);
            spi_sclk = 1'b1;
            wait_cyc(HALF);
        end
        reset = 1'b1;
        spi_cs = 1'b1;
        model_reset();
        wait_cyc(2);
        chk_reset_vals("midrst");
        reset = 1'b0;
        wait_cyc(4);
        quiet = 1'b1;

        txb[0] = 8'h80; txb[1] = 8'h00;
        run_frame(16, -1);
        chk("devid", rxb[1], 8'hE5);

        txb[0] = 8'h2D; txb[1] = 8'h08;
        run_frame(16, -1);
        chk("pc_write", power_ctl, 8'h08);
        txb[0] = 8'hAD; txb[1] = 8'h00;
        run_frame(16, -1);
        chk("pc_readback", rxb[1], 8'h08);

        txb[0] = 8'h2E; txb[1] = 8'h80;
        run_frame(16, -1);
        sample_idle(16'h1234, 16'hABCD, 16'h00FF);
        chk("int1_set", int1, 1'b1);
        txb[0] = 8'hF2;
        for (int k = 1; k < 7; k++) txb[k] = 8'h00;
        run_frame(56, -1);
        chk("burst0", rxb[1], 8'h34);
        chk("burst1", rxb[2], 8'h12);
        chk("burst2", rxb[3], 8'hCD);
        chk("burst3", rxb[4], 8'hAB);
        chk("burst4", rxb[5], 8'hFF);
        chk("burst5", rxb[6], 8'h00);
        chk("int1_cleared", int1, 1'b0);

        ax = 16'($urandom); ay = 16'($urandom); az = 16'($urandom);
        inj_x = 16'($urandom); inj_y = 16'($urandom); inj_z = 16'($urandom);
        sample_idle(ax, ay, az);
        run_frame(56, 3);
        for (int k = 0; k < 6; k++)
            chk("coherent_old", rxb[k+1], sbyte(ax, ay, az, k));
        chk("dr_kept", int1, 1'b1);
        run_frame(56, -1);
        for (int k = 0; k < 6; k++)
            chk("coherent_new", rxb[k+1], sbyte(inj_x, inj_y, inj_z, k));

        txb[0] = 8'h2C; txb[1] = 8'h55;
        run_frame(12, -1);
        chk("abort_bw", bw_rate, 8'h0A);

        txb[0] = 8'hFF; txb[1] = 8'h00; txb[2] = 8'h00;
        run_frame(24, -1);
        chk("wrap0", rxb[1], 8'h00);
        chk("wrap1", rxb[2], 8'hE5);

        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 2) == 0)
                sample_idle(16'($urandom), 16'($urandom), 16'($urandom));
            case ($urandom_range(0, 13))
                0:  ra = 6'h00;
                1:  ra = 6'h2C;
                2:  ra = 6'h2D;
                3:  ra = 6'h2E;
                4:  ra = 6'h30;
                5:  ra = 6'h31;
                6:  ra = 6'h32;
                7:  ra = 6'h33;
                8:  ra = 6'h34;
                9:  ra = 6'h35;
                10: ra = 6'h36;
                11: ra = 6'h37;
                12: ra = 6'h3F;
                default: ra = 6'($urandom);
            endcase
            txb[0] = {1'($urandom), 1'($urandom), ra};
            nb = $urandom_range(1, 4);
            for (int k = 1; k <= nb; k++) txb[k] = 8'($urandom);
            nbits = 8 * (nb + 1);
            if ($urandom_range(0, 7) == 0) nbits = nbits - $urandom_range(1, 7);
            run_frame(nbits, -1);
        end

        quiet = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
